// File: rtl/ex_operand_stage_pkg.sv
// rtl/ex_operand_stage_pkg.sv - shared widths, ALU opcodes and forward-select encoding
package ex_operand_stage_pkg;

    localparam int XLEN = 32;
    localparam int RA_W = 5;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_W   = 2'b01,
        FWD_M   = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/ex_operand_stage_fwd_unit.sv
// rtl/ex_operand_stage_fwd_unit.sv - forward-select generation for one E-stage operand
//   rs_i                       : registered source address of the operand
//   rd_m_i / reg_write_m_i     : M-stage destination and write enable
//   rd_w_i / reg_write_w_i     : W-stage destination and write enable
//   sel_o                      : FWD_M, FWD_W or FWD_REG
module fwd_unit
    import ex_operand_stage_pkg::*;
#(
    parameter int RA_W = ex_operand_stage_pkg::RA_W
) (
    input  logic [RA_W-1:0] rs_i,
    input  logic [RA_W-1:0] rd_m_i,
    input  logic            reg_write_m_i,
    input  logic [RA_W-1:0] rd_w_i,
    input  logic            reg_write_w_i,
    output logic [1:0]      sel_o
);

    // x0 is hardwired zero, so a write to it is never a forwarding source.
    // M is the younger producer and therefore wins over W.
    always_comb begin
        sel_o = FWD_REG;
        if (reg_write_m_i && (rd_m_i != '0) && (rd_m_i == rs_i)) begin
            sel_o = FWD_M;
        end else if (reg_write_w_i && (rd_w_i != '0) && (rd_w_i == rs_i)) begin
            sel_o = FWD_W;
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - ID/EX register with M/W operand forwarding and load-use stall
//   clk, reset                 : clock, asynchronous active-high reset
//   *D inputs                  : decoded D-stage fields and ValidD
//   FlushE, StallE             : bubble request / downstream hold
//   ALUResultM/RdM/RegWriteM   : M-stage forward source
//   ResultW/RdW/RegWriteW      : W-stage forward source
//   SrcAE/SrcBE/ALUControlE    : ALU operands and opcode
//   WriteDataE                 : forwarded rs2 (store data)
//   RdE/RegWriteE/MemReadE/ValidE : registered control
//   StallD/StallF              : hold requests to D and F
module ex_operand_stage
#(
    parameter int XLEN = ex_operand_stage_pkg::XLEN,
    parameter int RA_W = ex_operand_stage_pkg::RA_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    input  logic [XLEN-1:0] ImmExtD,
    input  logic [RA_W-1:0] Rs1D,
    input  logic [RA_W-1:0] Rs2D,
    input  logic [RA_W-1:0] RdD,
    input  logic            ALUSrcD,
    input  logic [2:0]      ALUControlD,
    input  logic            RegWriteD,
    input  logic            MemReadD,
    input  logic            ValidD,
    input  logic            FlushE,
    input  logic            StallE,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [RA_W-1:0] RdM,
    input  logic            RegWriteM,
    input  logic [XLEN-1:0] ResultW,
    input  logic [RA_W-1:0] RdW,
    input  logic            RegWriteW,
    output logic [XLEN-1:0] SrcAE,
    output logic [XLEN-1:0] SrcBE,
    output logic [2:0]      ALUControlE,
    output logic [XLEN-1:0] WriteDataE,
    output logic [RA_W-1:0] RdE,
    output logic            RegWriteE,
    output logic            MemReadE,
    output logic            ValidE,
    output logic            StallD,
    output logic            StallF
);

    import ex_operand_stage_pkg::*;

    logic            valid_q,     valid_d;
    logic            reg_write_q, reg_write_d;
    logic            mem_read_q,  mem_read_d;
    logic [2:0]      alu_ctrl_q,  alu_ctrl_d;
    logic [RA_W-1:0] rd_q,        rd_d;
    logic [RA_W-1:0] rs1_q,       rs1_d;
    logic [RA_W-1:0] rs2_q,       rs2_d;
    logic [XLEN-1:0] rd1_q,       rd1_d;
    logic [XLEN-1:0] rd2_q,       rd2_d;
    logic [XLEN-1:0] imm_q,       imm_d;
    logic            alu_src_q,   alu_src_d;

    logic            load_stall;
    logic [1:0]      fwd_a_sel;
    logic [1:0]      fwd_b_sel;
    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;

    // A load in E cannot forward its data until M completes, so a consumer in D must wait a cycle.
    assign load_stall = mem_read_q && valid_q && (rd_q != '0)
                        && ((rd_q == Rs1D) || (rd_q == Rs2D)) && ValidD;
    assign StallD = load_stall || StallE;
    assign StallF = load_stall || StallE;

    always_comb begin
        valid_d     = valid_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        alu_ctrl_d  = alu_ctrl_q;
        rd_d        = rd_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd1_d       = rd1_q;
        rd2_d       = rd2_q;
        imm_d       = imm_q;
        alu_src_d   = alu_src_q;
        if (StallE) begin
            // Hold: D is already held through StallD, so a pending load-use is not lost.
        end else if (FlushE || load_stall) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            alu_ctrl_d  = ALU_ADD;
            rd_d        = '0;
            rs1_d       = '0;
            rs2_d       = '0;
            rd1_d       = '0;
            rd2_d       = '0;
            imm_d       = '0;
            alu_src_d   = 1'b0;
        end else begin
            valid_d     = ValidD;
            reg_write_d = RegWriteD && ValidD;
            mem_read_d  = MemReadD && ValidD;
            alu_ctrl_d  = ALUControlD;
            rd_d        = RdD;
            rs1_d       = Rs1D;
            rs2_d       = Rs2D;
            rd1_d       = RD1D;
            rd2_d       = RD2D;
            imm_d       = ImmExtD;
            alu_src_d   = ALUSrcD;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            alu_ctrl_q  <= ALU_ADD;
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd1_q       <= '0;
            rd2_q       <= '0;
            imm_q       <= '0;
            alu_src_q   <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            alu_ctrl_q  <= alu_ctrl_d;
            rd_q        <= rd_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd1_q       <= rd1_d;
            rd2_q       <= rd2_d;
            imm_q       <= imm_d;
            alu_src_q   <= alu_src_d;
        end
    end

    fwd_unit #(.RA_W(RA_W)) u_fwd_a (
        .rs_i          (rs1_q),
        .rd_m_i        (RdM),
        .reg_write_m_i (RegWriteM),
        .rd_w_i        (RdW),
        .reg_write_w_i (RegWriteW),
        .sel_o         (fwd_a_sel)
    );

    fwd_unit #(.RA_W(RA_W)) u_fwd_b (
        .rs_i          (rs2_q),
        .rd_m_i        (RdM),
        .reg_write_m_i (RegWriteM),
        .rd_w_i        (RdW),
        .reg_write_w_i (RegWriteW),
        .sel_o         (fwd_b_sel)
    );

    always_comb begin
        case (fwd_a_sel)
            FWD_M:   fwd_a = ALUResultM;
            FWD_W:   fwd_a = ResultW;
            default: fwd_a = rd1_q;
        endcase
        case (fwd_b_sel)
            FWD_M:   fwd_b = ALUResultM;
            FWD_W:   fwd_b = ResultW;
            default: fwd_b = rd2_q;
        endcase
    end

    assign SrcAE       = fwd_a;
    assign WriteDataE  = fwd_b;
    assign SrcBE       = alu_src_q ? imm_q : fwd_b;
    assign ALUControlE = alu_ctrl_q;
    assign RdE         = rd_q;
    assign RegWriteE   = reg_write_q;
    assign MemReadE    = mem_read_q;
    assign ValidE      = valid_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb/tb_ex_operand_stage.sv - scoreboard bench for ex_operand_stage
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] RD1D, RD2D, ImmExtD, ALUResultM, ResultW;
    logic [4:0]  Rs1D, Rs2D, RdD, RdM, RdW;
    logic        ALUSrcD, RegWriteD, MemReadD, ValidD, FlushE, StallE, RegWriteM, RegWriteW;
    logic [2:0]  ALUControlD;
    logic [31:0] SrcAE, SrcBE, WriteDataE;
    logic [2:0]  ALUControlE;
    logic [4:0]  RdE;
    logic        RegWriteE, MemReadE, ValidE, StallD, StallF;

    always #5 clk = ~clk;

    ex_operand_stage dut (
        .clk(clk), .reset(reset), .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ALUSrcD(ALUSrcD), .ALUControlD(ALUControlD),
        .RegWriteD(RegWriteD), .MemReadD(MemReadD), .ValidD(ValidD), .FlushE(FlushE),
        .StallE(StallE), .ALUResultM(ALUResultM), .RdM(RdM), .RegWriteM(RegWriteM),
        .ResultW(ResultW), .RdW(RdW), .RegWriteW(RegWriteW), .SrcAE(SrcAE), .SrcBE(SrcBE),
        .ALUControlE(ALUControlE), .WriteDataE(WriteDataE), .RdE(RdE), .RegWriteE(RegWriteE),
        .MemReadE(MemReadE), .ValidE(ValidE), .StallD(StallD), .StallF(StallF)
    );

    // Instruction currently sitting in E, as the reference model sees it.
    typedef struct {
        bit        valid, rw, mr, asrc, data_ok;
        bit [2:0]  alu;
        bit [4:0]  rd, rs1, rs2;
        bit [31:0] rd1, rd2, imm;
    } instr_t;

    typedef struct {
        bit        valid, rw, mr, stall, data_ok;
        bit [2:0]  alu;
        bit [4:0]  rd;
        bit [31:0] srca, srcb, wd;
    } exp_t;

    instr_t m;
    exp_t   sb_q[$];
    int     checks = 0;
    int     errors = 0;

    function automatic instr_t empty_instr();
        instr_t e;
        e = '{default: 0};
        e.data_ok = 1;
        return e;
    endfunction

    // Youngest in-flight producer of a nonzero register supplies the operand.
    function automatic bit [31:0] operand(bit [4:0] rs, bit [31:0] regval);
        if (RegWriteM && RdM != 0 && RdM == rs) return ALUResultM;
        if (RegWriteW && RdW != 0 && RdW == rs) return ResultW;
        return regval;
    endfunction

    function automatic bit load_use();
        return m.mr && m.valid && m.rd != 0 && (m.rd == Rs1D || m.rd == Rs2D) && ValidD;
    endfunction

    function automatic exp_t predict();
        exp_t x;
        x.valid   = m.valid;
        x.rw      = m.rw;
        x.mr      = m.mr;
        x.alu     = m.alu;
        x.rd      = m.rd;
        x.data_ok = m.data_ok;
        x.stall   = load_use() || StallE;
        x.srca    = operand(m.rs1, m.rd1);
        x.wd      = operand(m.rs2, m.rd2);
        x.srcb    = m.asrc ? m.imm : x.wd;
        return x;
    endfunction

    task automatic clear_inputs();
        RD1D = 0; RD2D = 0; ImmExtD = 0; ALUResultM = 0; ResultW = 0;
        Rs1D = 0; Rs2D = 0; RdD = 0; RdM = 0; RdW = 0;
        ALUSrcD = 0; RegWriteD = 0; MemReadD = 0; ValidD = 0; FlushE = 0; StallE = 0;
        RegWriteM = 0; RegWriteW = 0; ALUControlD = 0;
    endtask

    // Called at a negedge with inputs already applied; ends at the next negedge.
    task automatic step();
        bit ls;
        #1;
        if (reset) m = empty_instr();
        sb_q.push_back(predict());
        @(posedge clk);
        ls = load_use();
        if (reset) begin
            m = empty_instr();
        end else if (StallE) begin
            // instruction stays in E
        end else if (FlushE || ls) begin
            m = empty_instr();
        end else if (ValidD) begin
            m.valid = 1; m.rw = RegWriteD; m.mr = MemReadD; m.alu = ALUControlD;
            m.rd = RdD; m.rs1 = Rs1D; m.rs2 = Rs2D; m.rd1 = RD1D; m.rd2 = RD2D;
            m.imm = ImmExtD; m.asrc = ALUSrcD; m.data_ok = 1;
        end else begin
            m.valid = 0; m.rw = 0; m.mr = 0; m.data_ok = 0;
        end
        @(negedge clk);
    endtask

    task automatic chk(string name, bit [31:0] act, bit [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: the DUT presents a settled E stage every cycle; compare it against the oldest prediction.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            #3;
            if (sb_q.size() != 0) begin
                x = sb_q.pop_front();
                chk("ValidE", ValidE, x.valid);
                chk("RegWriteE", RegWriteE, x.rw);
                chk("MemReadE", MemReadE, x.mr);
                chk("StallD", StallD, x.stall);
                chk("StallF", StallF, x.stall);
                if (x.data_ok) begin
                    chk("ALUControlE", ALUControlE, x.alu);
                    chk("RdE", RdE, x.rd);
                    chk("SrcAE", SrcAE, x.srca);
                    chk("SrcBE", SrcBE, x.srcb);
                    chk("WriteDataE", WriteDataE, x.wd);
                end
            end
        end
    end

    initial begin
        m = empty_instr();
        clear_inputs();
        @(negedge clk);

        // Reset while D holds a real instruction, then that instruction reaches E.
        reset = 1; ValidD = 1; RD1D = 32'h1234; Rs1D = 1; RdD = 2; RegWriteD = 1;
        step();
        reset = 0;
        step();
        step();

        // M and W both target x5: M wins; with RdM = 0 W supplies the value.
        clear_inputs();
        ValidD = 1; Rs1D = 5; RD1D = 32'h55; RdD = 6;
        step();
        StallE = 1;
        RegWriteM = 1; RdM = 5; ALUResultM = 32'hA5A5_0000;
        RegWriteW = 1; RdW = 5; ResultW = 32'h1;
        step();
        RdM = 0;
        step();

        // Immediate on SrcB while rs2 is forwarded from W into store data.
        clear_inputs();
        ValidD = 1; ALUSrcD = 1; ImmExtD = 32'hFFFF_FFFC; Rs2D = 7; RD2D = 32'h99;
        step();
        RegWriteW = 1; RdW = 7; ResultW = 32'h7;
        step();

        // Load-use: load to x3 in E, consumer of x3 in D.
        clear_inputs();
        ValidD = 1; MemReadD = 1; RegWriteD = 1; RdD = 3;
        step();
        MemReadD = 0; RdD = 4; Rs2D = 3; RD2D = 32'hCAFE; ALUControlD = 3'b010;
        step();
        step();
        step();

        // Load-use pending when reset arrives: stall drops at once.
        clear_inputs();
        ValidD = 1; MemReadD = 1; RegWriteD = 1; RdD = 3;
        step();
        MemReadD = 0; Rs1D = 3;
        reset = 1;
        step();
        reset = 0;
        step();

        // Flush squashes a valid instruction; flush with stall holds E.
        clear_inputs();
        ValidD = 1; FlushE = 1; ALUControlD = 3'b011; RdD = 9; RegWriteD = 1;
        step();
        FlushE = 0; RD1D = 32'h77; Rs1D = 8;
        step();
        FlushE = 1; StallE = 1; RdD = 12;
        step();
        step();

        // x0 is never a forwarding source.
        clear_inputs();
        ValidD = 1; Rs1D = 0; RD1D = 0;
        step();
        RegWriteM = 1; RdM = 0; ALUResultM = 32'hDEAD;
        step();

        // Randomized traffic on a small register window to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            reset       = ($urandom_range(0, 49) == 0);
            RD1D        = $urandom; RD2D = $urandom; ImmExtD = $urandom;
            Rs1D        = 5'($urandom_range(0, 3));
            Rs2D        = 5'($urandom_range(0, 3));
            RdD         = 5'($urandom_range(0, 3));
            ALUSrcD     = 1'($urandom_range(0, 1));
            ALUControlD = 3'($urandom_range(0, 4));
            RegWriteD   = 1'($urandom_range(0, 1));
            MemReadD    = ($urandom_range(0, 2) == 0);
            ValidD      = ($urandom_range(0, 7) != 0);
            FlushE      = ($urandom_range(0, 9) == 0);
            StallE      = ($urandom_range(0, 7) == 0);
            ALUResultM  = $urandom; ResultW = $urandom;
            RdM         = 5'($urandom_range(0, 3));
            RdW         = 5'($urandom_range(0, 3));
            RegWriteM   = 1'($urandom_range(0, 1));
            RegWriteW   = 1'($urandom_range(0, 1));
            step();
        end

        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d predictions left unchecked, expected 0", sb_q.size());
        end
        #5;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
